// File: rtl/aeolus_pkg.sv
// aeolus_pkg -- items shared by the aeolus sequencer files.
//   state_e      : sequencer FSM states, 3-bit encoding
//   PC_INC_STEP  : PC advance for a normal instruction
//   PC_INC_SKIP  : PC advance when a conditional skip is taken
package aeolus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam int unsigned PC_INC_STEP = 1;
  localparam int unsigned PC_INC_SKIP = 2;

endpackage

// File: rtl/aeolus_edge_detect.sv
// aeolus_edge_detect -- rising-edge detector with a registered previous value.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset (previous value cleared to 0)
//   in    : level input
//   rise  : high for the cycle in which in is 1 and was 0 on the previous edge
module aeolus_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= in;
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/aeolus_sequencer.sv
// aeolus_sequencer -- instruction sequencer: IDLE -> FETCH -> EXEC -> UPDATE.
// Decoding and the ALU live outside; this block only walks the ROM, latches
// the instruction and strobes exec_en once per instruction.
// Optional build macro: AEOLUS_SINGLE_STEP_EN adds a 'step' input; each
// rising edge of step starts one instruction from IDLE.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   run          : level run enable
//   halt_req     : stop after the current instruction (latched in FETCH/EXEC)
//   step         : single-step input (AEOLUS_SINGLE_STEP_EN only)
//   rom_data     : ROM word at address pc_out
//   skip_req     : decoded IR is a conditional skip
//   skip_cond    : ALU shift flag, sampled in EXEC
//   pc_out       : program counter / ROM address
//   ir_out       : latched instruction
//   exec_en      : one-cycle write strobe, high in EXEC only
//   halted       : high in HALT
//   retired      : retired-instruction count (skipped ones included), wraps
module aeolus_sequencer
  import aeolus_pkg::*;
#(
  parameter int                  PC_WIDTH  = 8,
  parameter int                  OP_WIDTH  = 4,
  parameter logic [PC_WIDTH-1:0] PROG_LAST = {PC_WIDTH{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                halt_req,
`ifdef AEOLUS_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [OP_WIDTH-1:0] rom_data,
  input  logic                skip_req,
  input  logic                skip_cond,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [OP_WIDTH-1:0] ir_out,
  output logic                exec_en,
  output logic                halted,
  output logic [7:0]          retired
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [OP_WIDTH-1:0] ir_q;
  logic [7:0]          ret_q;
  logic                skip_q;
  logic                halt_q;
  logic                start_go;

`ifdef AEOLUS_SINGLE_STEP_EN
  logic step_rise;

  aeolus_edge_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .in    (step),
    .rise  (step_rise)
  );

  assign start_go = run | step_rise;
`else
  assign start_go = run;
`endif

  // Halt decision uses the pre-update PC, so a skip jumping over PROG_LAST
  // does not halt.
  logic halt_now;
  assign halt_now = halt_req | halt_q | (pc_q == PROG_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_go) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (halt_now) state_d = ST_HALT;
        else if (run) state_d = ST_FETCH;
        else          state_d = ST_IDLE;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  logic [PC_WIDTH-1:0] pc_inc;
  logic [7:0]          ret_inc;
  assign pc_inc  = skip_q ? PC_WIDTH'(PC_INC_SKIP) : PC_WIDTH'(PC_INC_STEP);
  assign ret_inc = skip_q ? 8'(PC_INC_SKIP)        : 8'(PC_INC_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ret_q   <= '0;
      skip_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) ir_q <= rom_data;
      if (state_q == ST_EXEC)  skip_q <= skip_req & skip_cond;
      // Sticky halt request: caught in FETCH/EXEC, consumed in UPDATE.
      if ((state_q == ST_FETCH || state_q == ST_EXEC) && halt_req)
        halt_q <= 1'b1;
      if (state_q == ST_UPDATE) begin
        pc_q   <= pc_q + pc_inc;
        ret_q  <= ret_q + ret_inc;
        halt_q <= 1'b0;
      end
    end
  end

  assign pc_out  = pc_q;
  assign ir_out  = ir_q;
  assign retired = ret_q;
  assign exec_en = (state_q == ST_EXEC);
  assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_aeolus_sequencer.sv
// tb_aeolus_sequencer -- directed bench for aeolus_sequencer.
// u_b: PC_WIDTH=8, PROG_LAST=5.  u_a: PC_WIDTH=3 (PROG_LAST=7) for PC wrap.
// Opcode 4'hA is treated as the conditional-skip class by the bench decoder.
module tb_aeolus_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, halt_req, skip_cond;
`ifdef AEOLUS_SINGLE_STEP_EN
  logic       step;
`endif
  logic [3:0] rom_b [0:255];
  logic [3:0] rom_a [0:7];

  logic [7:0] pc_b;  logic [3:0] ir_b;  logic ex_b, hlt_b;  logic [7:0] ret_b;
  logic [2:0] pc_a;  logic [3:0] ir_a;  logic ex_a, hlt_a;  logic [7:0] ret_a;
  logic [3:0] rd_b, rd_a;
  logic       sk_b, sk_a;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign rd_b = rom_b[pc_b];
  assign rd_a = rom_a[pc_a];
  assign sk_b = (ir_b == 4'hA);
  assign sk_a = (ir_a == 4'hA);

  aeolus_sequencer #(.PROG_LAST(8'd5)) u_b (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
`ifdef AEOLUS_SINGLE_STEP_EN
    .step(step),
`endif
    .rom_data(rd_b), .skip_req(sk_b), .skip_cond(skip_cond),
    .pc_out(pc_b), .ir_out(ir_b), .exec_en(ex_b), .halted(hlt_b), .retired(ret_b)
  );

  aeolus_sequencer #(.PC_WIDTH(3)) u_a (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
`ifdef AEOLUS_SINGLE_STEP_EN
    .step(step),
`endif
    .rom_data(rd_a), .skip_req(sk_a), .skip_cond(skip_cond),
    .pc_out(pc_a), .ir_out(ir_a), .exec_en(ex_a), .halted(hlt_a), .retired(ret_a)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  // Leaves the DUTs in IDLE at a negedge with reset released; that is cyc 1.
  task automatic do_reset(input logic run_v, input logic cond_v);
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; skip_cond = cond_v;
`ifdef AEOLUS_SINGLE_STEP_EN
    step = 1'b0;
`endif
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0; run = run_v;
    cyc = 1;
  endtask

  task automatic count_pulses(input int n, inout int p);
    for (int i = 0; i < n; i++) begin
      tick();
      if (ex_b) p++;
    end
  endtask

  initial begin
    int p;
    for (int i = 0; i < 256; i++) rom_b[i] = 4'((i % 8) + 1);
    rom_b[4] = 4'hA;
    for (int i = 0; i < 8; i++) rom_a[i] = 4'h1;
    rom_a[6] = 4'hA;

    // Basic sequencing, taken skip at PC=4, wrap on the 3-bit instance.
    do_reset(1'b1, 1'b1);
    chk("rst_pc", pc_b, 0);
    chk("rst_ir", ir_b, 0);
    chk("rst_ret", ret_b, 0);
    chk("rst_halted", hlt_b, 0);
    chk("rst_exec", ex_b, 0);
    while (cyc <= 9) begin
      chk($sformatf("exec_c%0d", cyc), ex_b, (cyc % 3 == 0));
      if (cyc == 3) chk("ir_1", ir_b, 1);
      if (cyc == 6) chk("ir_2", ir_b, 2);
      if (cyc == 9) chk("ir_3", ir_b, 3);
      tick();
    end
    go_to(11);
    chk("pc_after3", pc_b, 3);
    chk("ret_after3", ret_b, 3);
    go_to(15);
    chk("skip_ir", ir_b, 4'hA);
    go_to(17);
    chk("skip_taken_pc", pc_b, 6);
    chk("skip_taken_ret", ret_b, 6);
    chk("skip_no_halt", hlt_b, 0);
    go_to(23);
    chk("wrap_pc", pc_a, 0);
    chk("wrap_ret", ret_a, 8);
    go_to(24);
    chk("wrap_no_halt", hlt_a, 0);

    // Not-taken skip, then halt at PROG_LAST; run toggles are ignored.
    do_reset(1'b1, 1'b0);
    go_to(17);
    chk("skip_nt_pc", pc_b, 5);
    go_to(19);
    chk("pre_halt", hlt_b, 0);
    go_to(20);
    chk("halt_at_last", hlt_b, 1);
    chk("halt_pc", pc_b, 6);
    chk("halt_ret", ret_b, 6);
    p = 0;
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      count_pulses(1, p);
    end
    chk("halt_no_exec", p, 0);
    chk("halt_sticky", hlt_b, 1);
    chk("halt_pc_stable", pc_b, 6);

    // One-cycle halt_req in FETCH of the PC=1 instruction.
    do_reset(1'b1, 1'b0);
    go_to(5);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("hreq_exec", ex_b, 1);
    chk("hreq_ir", ir_b, 2);
    go_to(7);
    chk("hreq_not_yet", hlt_b, 0);
    go_to(8);
    chk("hreq_halted", hlt_b, 1);
    chk("hreq_pc", pc_b, 2);
    chk("hreq_ret", ret_b, 2);

    // Reset asserted during EXEC.
    do_reset(1'b1, 1'b0);
    go_to(3);
    chk("rexec_exec", ex_b, 1);
    reset = 1'b1; run = 1'b0;
    tick();
    chk("rexec_exec_off", ex_b, 0);
    chk("rexec_pc", pc_b, 0);
    chk("rexec_ir", ir_b, 0);
    reset = 1'b0;
    p = 0;
    count_pulses(5, p);
    chk("rexec_idle", p, 0);
    chk("rexec_pc_hold", pc_b, 0);
    run = 1'b1;
    tick(); tick();
    chk("rexec_restart", ex_b, 1);

`ifdef AEOLUS_SINGLE_STEP_EN
    do_reset(1'b0, 1'b0);
    p = 0;
    count_pulses(2, p);
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      count_pulses(1, p);
      step = 1'b0;
      count_pulses(6, p);
    end
    chk("step_pulses", p, 2);
    chk("step_ret", ret_b, 2);
    p = 0;
    step = 1'b1;
    count_pulses(12, p);
    step = 1'b0;
    chk("step_held_pulses", p, 1);
    chk("step_held_ret", ret_b, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aeolus_sequencer.md
AEOLUS_SEQUENCER -- requirements
Module: aeolus_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8: program counter and ROM address width.
REQ-002 SHALL have parameter OP_WIDTH, default 4: opcode width.
REQ-003 SHALL have parameter PROG_LAST, default {PC_WIDTH{1'b1}}: address of the last program word.
REQ-004 SHALL have port clk  input  1  system clock; reset is synchronous and active-high, and all state is sampled on the rising edge of clk.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port run  input  1  level-sensitive run enable.
REQ-007 SHALL have port halt_req  input  1  request to stop after the current instruction.
REQ-008 SHALL have port rom_data  input  OP_WIDTH  combinational ROM output for address pc_out.
REQ-009 SHALL have port skip_req  input  1  decoded IR is a conditional skip (SNZA/SNZS class).
REQ-010 SHALL have port skip_cond  input  1  ALU shift flag, sampled in EXEC.
REQ-011 SHALL have port pc_out  output  PC_WIDTH  current program counter, which is the ROM address.
REQ-012 SHALL have port ir_out  output  OP_WIDTH  latched instruction, which feeds the decoder.
REQ-013 SHALL have port exec_en  output  1  one-cycle strobe that gates all register, accumulator and shift-register writes.
REQ-014 SHALL have port halted  output  1  high while in HALT.
REQ-015 SHALL have port retired  output  8  count of retired instructions, including skipped ones; it wraps.

Function
REQ-016 SHALL implement the states IDLE, FETCH, EXEC, UPDATE and HALT.
REQ-017 SHALL transition IDLE->FETCH when run=1; otherwise it SHALL stay in IDLE.
REQ-018 SHALL transition FETCH->EXEC unconditionally and load ir_out<=rom_data on that edge.
REQ-019 SHALL hold exec_en=1 in EXEC only, for exactly one cycle per instruction, and EXEC SHALL transition to UPDATE.
REQ-020 SHALL capture skip_taken<=skip_req&skip_cond in EXEC.
REQ-021 SHALL in UPDATE set pc_out<=pc_out+2 if skip_taken, else pc_out+1, with modulo-2^PC_WIDTH wrap, and SHALL set retired<=retired+1 (+2 if skip_taken).
REQ-022 SHALL transition UPDATE->HALT if halt_req=1 or pc_out==PROG_LAST; else UPDATE->FETCH if run=1; else UPDATE->IDLE.
REQ-023 SHALL remain in HALT until reset and SHALL ignore run in HALT.
REQ-024 SHALL produce a steady-state latency of 3 cycles per instruction (FETCH, EXEC, UPDATE).
REQ-025 SHALL give a skip at PROG_LAST-1 PC=PROG_LAST+1 after wrap, and SHALL NOT halt in that case because the PROG_LAST compare uses the pre-update PC.
REQ-026 SHALL latch halt_req asserted in FETCH or EXEC (sticky until UPDATE) and SHALL still complete the current instruction.
REQ-027 SHALL hold pc_out, ir_out and retired stable outside their update states.
REQ-028 SHALL keep exec_en=0 in every state other than EXEC, including HALT and IDLE.

Reset
REQ-029 SHALL on reset=1 at a clock edge set state=IDLE, pc_out=0, ir_out=0, retired=0, skip_taken=0, the halt latch to 0, exec_en=0 and halted=0.
REQ-030 SHALL let reset mid-instruction abort the instruction with no exec_en pulse after the reset edge.
REQ-031 SHALL give reset priority over every other input.

Configuration
REQ-032 SHALL, with AEOLUS_SINGLE_STEP_EN defined, add input step (1 bit).
REQ-033 SHALL, with AEOLUS_SINGLE_STEP_EN defined, edge-detect step with a registered previous value.
REQ-034 SHALL, with AEOLUS_SINGLE_STEP_EN defined, replace the IDLE->FETCH condition by run|step_rise, and the UPDATE->FETCH condition by run.
REQ-035 SHALL, with AEOLUS_SINGLE_STEP_EN defined, execute exactly one instruction per step rising edge while run=0.
REQ-036 SHALL, without AEOLUS_SINGLE_STEP_EN, have no step port and behave as in the Function section.

Structure
REQ-037 SHALL place the state enum (3-bit encoding) and the PC increment constants (1, 2) in shared package aeolus_pkg.
REQ-038 SHALL place the step edge detector in sub-module aeolus_edge_detect (clk, reset, in, rise), instantiated only under AEOLUS_SINGLE_STEP_EN.
REQ-039 SHALL NOT contain an ALU or a decoder; decoding stays external.

Verification
REQ-040 SHALL verify basic sequencing: reset, run=1, ROM {0x1,0x2,0x3} -> exec_en pulses at cycles 3,6,9 after reset release, ir_out=1,2,3 and pc_out=3 after the third UPDATE.
REQ-041 SHALL verify a taken skip: IR skip_req=1 at PC=4, skip_cond=1 -> pc_out=6 and retired increments by 2.
REQ-042 SHALL verify a not-taken skip: skip_req=1 and skip_cond=0 at PC=4 -> pc_out=5.
REQ-043 SHALL verify halt: PROG_LAST=5, run=1 -> halted=1 after the UPDATE at PC=5, and run toggles do not restart the sequencer; a one-cycle halt_req pulse in FETCH -> that instruction completes, then HALT.
REQ-044 SHALL verify reset in EXEC: reset=1 in EXEC -> exec_en=0 on the next cycle, pc_out=0, state=IDLE.
REQ-045 SHALL verify single step: with AEOLUS_SINGLE_STEP_EN, run=0 and two step pulses -> exactly two exec_en pulses and retired=2; a held step -> one instruction only.
